pic_bank_ctrl: RTL and testbench



---
 rtl/pic_bank_ctrl_if.sv | 23 ++
 rtl/pic_bank_ctrl.sv | 156 +++++++++++++++
 tb/tb_pic_bank_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_bank_ctrl_if.sv
// rtl/pic_bank_ctrl_if.sv - pixel position in, RAM read port and writer handshake out
interface pic_bank_ctrl_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        wr_done_tog;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic        pic_valid;
    logic        wr_bank;
    logic        wr_ready;
    logic        frame_end;
    logic [7:0]  overrun_cnt;

    modport master (
        output pix_x, pix_y, wr_done_tog,
        input  rd_en, rd_addr, pic_valid, wr_bank, wr_ready, frame_end, overrun_cnt
    );

    modport slave (
        input  pix_x, pix_y, wr_done_tog,
        output rd_en, rd_addr, pic_valid, wr_bank, wr_ready, frame_end, overrun_cnt
    );
endinterface

// File: rtl/pic_bank_ctrl.sv
// rtl/pic_bank_ctrl.sv - ping-pong bank controller for the centred VGA picture window
module pic_bank_ctrl #(
    parameter int H_VALID  = 640,
    parameter int V_VALID  = 480,
    parameter int H_PIC    = 98,
    parameter int V_PIC    = 98,
    parameter int PIC_SIZE = 9604
) (
    input  logic           vga_clk,
    input  logic           sys_rst_n,
    pic_bank_ctrl_if.slave bus
);

    localparam int HS = (H_VALID - H_PIC) / 2;
    localparam int VS = (V_VALID - V_PIC) / 2;

    // Window opens one pixel early so RAM q lines up with the first visible pixel.
    localparam logic [9:0]  X_FIRST   = 10'(HS - 1);
    localparam logic [9:0]  X_END     = 10'(HS + H_PIC - 1);
    localparam logic [9:0]  Y_FIRST   = 10'(VS);
    localparam logic [9:0]  Y_END     = 10'(VS + V_PIC);
    localparam logic [9:0]  X_LAST    = 10'(H_VALID - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_VALID - 1);
    localparam logic [13:0] ADDR_LAST = 14'(PIC_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        sync_s1;
    logic        sync_s2;
    logic        sync_s3;
    logic        wr_done;
    logic        frame_end;
    logic        rd_en;
    logic [13:0] addr_cnt;
    logic        pic_valid;
    logic        have_pic;
    logic        have_pic_nxt;
    logic        rd_bank;
    logic        rd_bank_nxt;
    logic        wr_bank;
    logic        wr_bank_nxt;
    logic        wr_ready;
    logic [7:0]  overrun_cnt;
    logic [7:0]  overrun_nxt;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
            sync_s3 <= 1'b0;
        end else begin
            sync_s1 <= bus.wr_done_tog;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    assign wr_done = sync_s2 ^ sync_s3;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_end <= 1'b0;
        end else begin
            frame_end <= (bus.pix_x == X_LAST) && (bus.pix_y == Y_LAST);
        end
    end

    assign rd_en = (bus.pix_x >= X_FIRST) && (bus.pix_x < X_END) &&
                   (bus.pix_y >= Y_FIRST) && (bus.pix_y < Y_END);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addr_cnt <= 14'd0;
        end else if (frame_end) begin
            addr_cnt <= 14'd0;
        end else if (rd_en) begin
            addr_cnt <= (addr_cnt == ADDR_LAST) ? 14'd0 : addr_cnt + 14'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pic_valid <= 1'b0;
        end else begin
            pic_valid <= rd_en && have_pic;
        end
    end

    always_comb begin
        state_nxt    = state;
        have_pic_nxt = have_pic;
        rd_bank_nxt  = rd_bank;
        wr_bank_nxt  = wr_bank;
        overrun_nxt  = overrun_cnt;
        case (state)
            IDLE: begin
                if (wr_done) begin
                    state_nxt = PEND;
                end
            end
            SHOW: begin
                // A coincident frame_end is ignored here; the swap waits a full frame.
                if (wr_done) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (wr_done && (overrun_cnt != 8'hFF)) begin
                    overrun_nxt = overrun_cnt + 8'd1;
                end
                if (frame_end) begin
                    rd_bank_nxt  = wr_bank;
                    wr_bank_nxt  = ~wr_bank;
                    have_pic_nxt = 1'b1;
                    state_nxt    = SHOW;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            have_pic    <= 1'b0;
            rd_bank     <= 1'b0;
            wr_bank     <= 1'b0;
            overrun_cnt <= 8'd0;
            wr_ready    <= 1'b1;
        end else begin
            state       <= state_nxt;
            have_pic    <= have_pic_nxt;
            rd_bank     <= rd_bank_nxt;
            wr_bank     <= wr_bank_nxt;
            overrun_cnt <= overrun_nxt;
            wr_ready    <= (state_nxt != PEND);
        end
    end

    assign bus.rd_en       = rd_en;
    assign bus.rd_addr     = {rd_bank, addr_cnt};
    assign bus.pic_valid   = pic_valid;
    assign bus.wr_bank     = wr_bank;
    assign bus.wr_ready    = wr_ready;
    assign bus.frame_end   = frame_end;
    assign bus.overrun_cnt = overrun_cnt;

endmodule

// File: tb/tb_pic_bank_ctrl.sv
// tb/tb_pic_bank_ctrl.sv - randomized bench for pic_bank_ctrl against a frame-level model
module tb_pic_bank_ctrl;

    localparam int HV = 640;
    localparam int VV = 480;
    localparam int HP = 98;
    localparam int VP = 98;
    localparam int PS = 9604;
    localparam int HS = 271;
    localparam int VS = 191;
    localparam int BLANK = 1023;

    logic vga_clk = 1'b0;
    logic sys_rst_n = 1'b0;

    always #5 vga_clk = ~vga_clk;

    pic_bank_ctrl_if bus();

    pic_bank_ctrl #(
        .H_VALID (HV),
        .V_VALID (VV),
        .H_PIC   (HP),
        .V_PIC   (VP),
        .PIC_SIZE(PS)
    ) dut (
        .vga_clk  (vga_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which picture is on screen, whether a finished one waits.
    bit m_pend, m_have, m_disp, m_target, m_fe, m_pv, m_level;
    int m_ovr, m_rcount;
    int ev_q[$];

    int n_pv, n_fe, n_rden, n_rd_b1, n_pv_post;
    int mm_pv, mm_addr, mm_ctl, mm_rden;
    int addr_post;
    bit pv_before, pv_after, post_rst;
    int hits[PS];
    int line_pv[VV];

    function automatic bit in_win(input int x, input int y);
        return (x >= HS - 1) && (x < HS + HP - 1) && (y >= VS) && (y < VS + VP);
    endfunction

    task automatic model_reset();
        m_pend = 0; m_have = 0; m_disp = 0; m_target = 0; m_fe = 0; m_pv = 0; m_level = 0;
        m_ovr = 0; m_rcount = 0;
        ev_q.delete();
    endtask

    task automatic clear_obs();
        n_pv = 0; n_fe = 0; n_rden = 0; n_rd_b1 = 0; n_pv_post = 0;
        mm_pv = 0; mm_addr = 0; mm_ctl = 0; mm_rden = 0;
        addr_post = -1; pv_before = 0; pv_after = 1; post_rst = 0;
        foreach (hits[i]) hits[i] = 0;
        foreach (line_pv[i]) line_pv[i] = 0;
    endtask

    task automatic tick(input int x, input int y);
        bit rdn;
        int wd;
        int idx;
        bus.pix_x = 10'(x);
        bus.pix_y = 10'(y);
        if (sys_rst_n && (bus.wr_done_tog != m_level)) begin
            ev_q.push_back(3);
            m_level = bus.wr_done_tog;
        end
        #1;
        rdn = in_win(x, y);
        if (bus.rd_en !== rdn) mm_rden++;
        if (bus.pic_valid !== m_pv) mm_pv++;
        if (bus.pic_valid === 1'b1) begin
            n_pv++;
            if (y < VV) line_pv[y]++;
            if (post_rst) n_pv_post++;
        end
        if (bus.frame_end === 1'b1) n_fe++;
        if (bus.frame_end !== m_fe) mm_ctl++;
        if (bus.rd_addr !== {m_disp, 14'(m_rcount)}) mm_addr++;
        if ((bus.wr_ready !== !m_pend) || (bus.wr_bank !== m_target) ||
            (bus.overrun_cnt !== 8'(m_ovr))) mm_ctl++;
        if (rdn) begin
            n_rden++;
            idx = int'(bus.rd_addr[13:0]);
            if (idx < PS) hits[idx]++;
            else mm_addr++;
            if (bus.rd_addr[14] === 1'b1) n_rd_b1++;
        end
        @(posedge vga_clk);
        wd = 0;
        foreach (ev_q[i]) ev_q[i]--;
        while ((ev_q.size() > 0) && (ev_q[0] == 0)) begin
            void'(ev_q.pop_front());
            wd++;
        end
        if (!sys_rst_n) begin
            model_reset();
        end else begin
            m_pv = rdn && m_have;
            if (m_fe) m_rcount = 0;
            else if (rdn) m_rcount = (m_rcount + 1) % PS;
            if (m_pend) begin
                if (wd > 0) m_ovr = (m_ovr + wd > 255) ? 255 : m_ovr + wd;
                if (m_fe) begin
                    m_disp = m_target;
                    m_target = !m_target;
                    m_have = 1;
                    m_pend = 0;
                end
            end else if (wd > 0) begin
                m_pend = 1;
            end
            m_fe = (x == HV - 1) && (y == VV - 1);
        end
        #1;
    endtask

    task automatic pre_tick(input int c, input int tog_at, input int rst_at);
        if (c == tog_at) bus.wr_done_tog = ~bus.wr_done_tog;
        if ((rst_at >= 0) && (c == rst_at)) begin
            pv_before = bus.pic_valid;
            sys_rst_n = 1'b0;
            bus.wr_done_tog = 1'b0;
            #1;
            pv_after = bus.pic_valid;
            model_reset();
            post_rst = 1;
        end
        if ((rst_at >= 0) && (c == rst_at + 5)) sys_rst_n = 1'b1;
    endtask

    // Compressed frame: only the window neighbourhood and the final active pixel are visited.
    task automatic drive_frame(input bit window, input int tog_at, input int rst_at);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) begin pre_tick(c, tog_at, rst_at); tick(BLANK, BLANK); c++; end
        if (window) begin
            for (int y = VS - 1; y <= VS + VP; y++) begin
                for (int x = HS - 5; x <= HS + HP + 3; x++) begin
                    pre_tick(c, tog_at, rst_at); tick(x, y); c++;
                end
                for (int i = 0; i < 2; i++) begin pre_tick(c, tog_at, rst_at); tick(BLANK, BLANK); c++; end
            end
            addr_post = int'(bus.rd_addr[13:0]);
            for (int i = 0; i < 4; i++) begin pre_tick(c, tog_at, rst_at); tick(BLANK, BLANK); c++; end
        end
        pre_tick(c, tog_at, rst_at); tick(HV - 1, VV - 1); c++;
        for (int i = 0; i < 6; i++) begin pre_tick(c, tog_at, rst_at); tick(BLANK, BLANK); c++; end
    endtask

    task automatic test_reset();
        int x, y;
        sys_rst_n = 1'b0;
        bus.wr_done_tog = 1'b0;
        model_reset();
        clear_obs();
        tick(300, 200);
        checks++; if (bus.rd_en !== 1'b1) begin errors++; $display("FAIL reset_rd_en_comb got %0b want 1", bus.rd_en); end
        tick(HV - 1, VV - 1);
        tick(BLANK, BLANK);
        checks++; if (bus.pic_valid !== 1'b0) begin errors++; $display("FAIL reset_pic_valid got %0b want 0", bus.pic_valid); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %0b want 1", bus.wr_ready); end
        checks++; if (bus.wr_bank !== 1'b0) begin errors++; $display("FAIL reset_wr_bank got %0b want 0", bus.wr_bank); end
        checks++; if (bus.rd_addr !== 15'd0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr); end
        checks++; if (bus.overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun got %0d want 0", bus.overrun_cnt); end
        checks++; if (bus.frame_end !== 1'b0) begin errors++; $display("FAIL reset_frame_end got %0b want 0", bus.frame_end); end
        for (int i = 0; i < 40; i++) begin
            x = $urandom_range(HS - 3, HS + HP + 1);
            y = $urandom_range(VS - 2, VS + VP + 1);
            tick(x, y);
        end
        checks++; if (mm_rden != 0) begin errors++; $display("FAIL reset_rd_en_random mismatches %0d want 0", mm_rden); end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(BLANK, BLANK);
    endtask

    task automatic test_first_picture();
        int bad_lines, bad_hits;
        clear_obs();
        bus.wr_done_tog = ~bus.wr_done_tog;
        tick(BLANK, BLANK);
        tick(BLANK, BLANK);
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL first_wr_ready_edge2 got %0b want 1", bus.wr_ready); end
        tick(BLANK, BLANK);
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL first_wr_ready_edge3 got %0b want 0", bus.wr_ready); end
        drive_frame(0, -1, -1);
        checks++; if (bus.rd_addr[14] !== 1'b0) begin errors++; $display("FAIL first_rd_bank got %0b want 0", bus.rd_addr[14]); end
        checks++; if (bus.wr_bank !== 1'b1) begin errors++; $display("FAIL first_wr_bank got %0b want 1", bus.wr_bank); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL first_wr_ready_swap got %0b want 1", bus.wr_ready); end
        clear_obs();
        drive_frame(1, -1, -1);
        bad_lines = 0;
        for (int y = VS; y < VS + VP; y++) if (line_pv[y] != HP) bad_lines++;
        bad_hits = 0;
        foreach (hits[i]) if (hits[i] != 1) bad_hits++;
        checks++; if (n_pv != PS) begin errors++; $display("FAIL sweep_pic_valid_total got %0d want %0d", n_pv, PS); end
        checks++; if (bad_lines != 0) begin errors++; $display("FAIL sweep_lines_not_98 got %0d want 0", bad_lines); end
        checks++; if (line_pv[VS - 1] + line_pv[VS + VP] != 0) begin errors++; $display("FAIL sweep_edge_lines got %0d want 0", line_pv[VS - 1] + line_pv[VS + VP]); end
        checks++; if (n_rden != PS) begin errors++; $display("FAIL sweep_rd_en_count got %0d want %0d", n_rden, PS); end
        checks++; if (bad_hits != 0) begin errors++; $display("FAIL sweep_addr_not_once got %0d want 0", bad_hits); end
        checks++; if (addr_post != 0) begin errors++; $display("FAIL sweep_addr_after_window got %0d want 0", addr_post); end
        checks++; if (n_fe != 1) begin errors++; $display("FAIL sweep_frame_end_pulses got %0d want 1", n_fe); end
        checks++; if (mm_pv + mm_addr + mm_ctl + mm_rden != 0) begin errors++;
            $display("FAIL sweep_model pv=%0d addr=%0d ctl=%0d rden=%0d want 0", mm_pv, mm_addr, mm_ctl, mm_rden); end
    endtask

    task automatic test_second_picture();
        int tog_at;
        clear_obs();
        tog_at = $urandom_range(5, 10000);
        drive_frame(1, tog_at, -1);
        checks++; if (n_rd_b1 != 0) begin errors++; $display("FAIL second_bank_mid_frame got %0d want 0", n_rd_b1); end
        checks++; if (n_pv != PS) begin errors++; $display("FAIL second_pv_old_frame got %0d want %0d", n_pv, PS); end
        checks++; if (bus.rd_addr[14] !== 1'b1) begin errors++; $display("FAIL second_rd_bank got %0b want 1", bus.rd_addr[14]); end
        checks++; if (bus.wr_bank !== 1'b0) begin errors++; $display("FAIL second_wr_bank got %0b want 0", bus.wr_bank); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL second_wr_ready got %0b want 1", bus.wr_ready); end
        clear_obs();
        drive_frame(1, -1, -1);
        checks++; if (n_rd_b1 != PS) begin errors++; $display("FAIL second_bank1_reads got %0d want %0d", n_rd_b1, PS); end
        checks++; if (mm_pv + mm_addr + mm_ctl + mm_rden != 0) begin errors++;
            $display("FAIL second_model pv=%0d addr=%0d ctl=%0d rden=%0d want 0", mm_pv, mm_addr, mm_ctl, mm_rden); end
    endtask

    task automatic test_overrun();
        clear_obs();
        bus.wr_done_tog = ~bus.wr_done_tog;
        for (int i = 0; i < 4; i++) tick(BLANK, BLANK);
        bus.wr_done_tog = ~bus.wr_done_tog;
        for (int i = 0; i < 6; i++) tick(BLANK, BLANK);
        bus.wr_done_tog = ~bus.wr_done_tog;
        for (int i = 0; i < 6; i++) tick(BLANK, BLANK);
        checks++; if (bus.overrun_cnt !== 8'd2) begin errors++; $display("FAIL overrun_two got %0d want 2", bus.overrun_cnt); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL overrun_still_pend got %0b want 0", bus.wr_ready); end
        for (int i = 0; i < 300; i++) begin
            bus.wr_done_tog = ~bus.wr_done_tog;
            tick(BLANK, BLANK);
        end
        for (int i = 0; i < 4; i++) tick(BLANK, BLANK);
        checks++; if (bus.overrun_cnt !== 8'd255) begin errors++; $display("FAIL overrun_saturate got %0d want 255", bus.overrun_cnt); end
        drive_frame(0, -1, -1);
        checks++; if (bus.rd_addr[14] !== 1'b0) begin errors++; $display("FAIL overrun_swap_rd_bank got %0b want 0", bus.rd_addr[14]); end
        checks++; if (bus.wr_bank !== 1'b1) begin errors++; $display("FAIL overrun_swap_wr_bank got %0b want 1", bus.wr_bank); end
        checks++; if (mm_ctl + mm_addr != 0) begin errors++; $display("FAIL overrun_model ctl=%0d addr=%0d want 0", mm_ctl, mm_addr); end
    endtask

    task automatic test_coincide_show();
        clear_obs();
        drive_frame(0, 3, -1);
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL coincide_show_pend got %0b want 0", bus.wr_ready); end
        checks++; if (bus.rd_addr[14] !== 1'b0) begin errors++; $display("FAIL coincide_show_no_swap got %0b want 0", bus.rd_addr[14]); end
        checks++; if (bus.overrun_cnt !== 8'd255) begin errors++; $display("FAIL coincide_show_overrun got %0d want 255", bus.overrun_cnt); end
        drive_frame(0, -1, -1);
        checks++; if (bus.rd_addr[14] !== 1'b1) begin errors++; $display("FAIL coincide_show_later_swap got %0b want 1", bus.rd_addr[14]); end
        checks++; if (bus.wr_bank !== 1'b0) begin errors++; $display("FAIL coincide_show_wr_bank got %0b want 0", bus.wr_bank); end
        checks++; if (mm_ctl != 0) begin errors++; $display("FAIL coincide_show_model ctl=%0d want 0", mm_ctl); end
    endtask

    task automatic test_reset_mid();
        int rst_at;
        clear_obs();
        rst_at = 4 + $urandom_range(10, 80) * 109 + $urandom_range(15, 90);
        drive_frame(1, -1, rst_at);
        checks++; if (pv_before !== 1'b1) begin errors++; $display("FAIL rstmid_pv_before got %0b want 1", pv_before); end
        checks++; if (pv_after !== 1'b0) begin errors++; $display("FAIL rstmid_pv_drop got %0b want 0", pv_after); end
        checks++; if (n_pv_post != 0) begin errors++; $display("FAIL rstmid_pv_after_release got %0d want 0", n_pv_post); end
        checks++; if (bus.overrun_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_overrun got %0d want 0", bus.overrun_cnt); end
        checks++; if (bus.rd_addr !== 15'd0) begin errors++; $display("FAIL rstmid_rd_addr got %0d want 0", bus.rd_addr); end
        drive_frame(0, 3, -1);
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL coincide_idle_pend got %0b want 0", bus.wr_ready); end
        checks++; if (bus.wr_bank !== 1'b0) begin errors++; $display("FAIL coincide_idle_no_swap got %0b want 0", bus.wr_bank); end
        drive_frame(0, -1, -1);
        checks++; if (bus.wr_bank !== 1'b1) begin errors++; $display("FAIL rstmid_swap_wr_bank got %0b want 1", bus.wr_bank); end
        checks++; if (bus.rd_addr[14] !== 1'b0) begin errors++; $display("FAIL rstmid_swap_rd_bank got %0b want 0", bus.rd_addr[14]); end
        clear_obs();
        drive_frame(1, -1, -1);
        checks++; if (n_pv != PS) begin errors++; $display("FAIL rstmid_pv_restored got %0d want %0d", n_pv, PS); end
        checks++; if (mm_pv + mm_addr + mm_ctl + mm_rden != 0) begin errors++;
            $display("FAIL rstmid_model pv=%0d addr=%0d ctl=%0d rden=%0d want 0", mm_pv, mm_addr, mm_ctl, mm_rden); end
    endtask

    initial begin
        bus.pix_x = 10'h3FF;
        bus.pix_y = 10'h3FF;
        bus.wr_done_tog = 1'b0;
        test_reset();
        test_first_picture();
        test_second_picture();
        test_overrun();
        test_coincide_show();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
